// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle single-precision adder: one FSM steps a shared align/add/normalize/pack datapath.
// Define FP_ADD_RNE_EN to round to nearest-even in PACK; otherwise the result is truncated.

module count_leading_zeros #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);
  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++)
      if (value[i]) count = CW'(W - 1 - i);
  end
endmodule

module fp_add_seq_ctrl #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int DIFF_SAT = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     busy
);
  localparam int FW = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 1;       // mantissa with hidden bit
  localparam int VW = MAN_W + 4;       // {mant, G, R, S}
  localparam int EW = EXP_W + 2;       // signed exponent with headroom
  localparam int LW = $clog2(MW + 1);
  localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK, DONE} state_t;
  state_t state, state_n;

  logic [FW-1:0]           op_a, op_b;
  logic                    sign_l, eff_sub, zero_r;
  logic [EXP_W-1:0]        exp_l;
  logic [VW-1:0]           vec_l, vec_s, norm;
  logic [VW:0]             sum;
  logic signed [EW-1:0]    exp_n;
  logic [FW-1:0]           result_r;
  logic                    ovf_r;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ALIGN;
      end
      ALIGN: state_n = ADD;
      ADD:   state_n = NORM;
      NORM:  state_n = PACK;
      PACK:  state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ALIGN: unpack with denormal flush, order by magnitude, shift smaller into GRS
  logic [EXP_W-1:0] ea, eb, el_c, es_c, diff;
  logic [MW-1:0]    ma, mb, ml_c, ms_c;
  logic             a_big, sl_c, ss_c, lost;
  logic [VW-1:0]    ms_vec, shv, vs_c;

  always_comb begin
    ea     = op_a[FW-2 -: EXP_W];
    eb     = op_b[FW-2 -: EXP_W];
    ma     = (ea == '0) ? '0 : {1'b1, op_a[MAN_W-1:0]};
    mb     = (eb == '0) ? '0 : {1'b1, op_b[MAN_W-1:0]};
    a_big  = {ea, ma} >= {eb, mb};
    el_c   = a_big ? ea : eb;
    es_c   = a_big ? eb : ea;
    ml_c   = a_big ? ma : mb;
    ms_c   = a_big ? mb : ma;
    sl_c   = a_big ? op_a[FW-1] : op_b[FW-1];
    ss_c   = a_big ? op_b[FW-1] : op_a[FW-1];
    diff   = el_c - es_c;
    ms_vec = {ms_c, 3'b000};
    shv    = '0;
    lost   = 1'b0;
    if (diff >= EXP_W'(DIFF_SAT)) begin
      vs_c = {{(VW-1){1'b0}}, |ms_c};
    end else begin
      shv  = ms_vec >> diff;
      lost = |(ms_vec & ((VW'(1) << diff) - VW'(1)));
      vs_c = {shv[VW-1:1], shv[0] | lost};
    end
  end

  // NORM: single leading-zero counter on the integer part of the sum
  logic [LW-1:0]        lz;
  logic [VW-1:0]        norm_c;
  logic signed [EW-1:0] exp_c;

  count_leading_zeros #(.W(MW)) u_clz (.value(sum[VW-1:3]), .count(lz));

  always_comb begin
    if (sum[VW]) begin
      norm_c = {sum[VW:2], sum[1] | sum[0]};
      exp_c  = signed'(EW'(exp_l)) + EW'(1);
    end else begin
      norm_c = sum[VW-1:0] << lz;
      exp_c  = signed'(EW'(exp_l)) - signed'(EW'(lz));
    end
  end

  // PACK
  logic [MAN_W-1:0]     frac_p;
  logic signed [EW-1:0] exp_p;
  logic [FW-1:0]        res_c;
  logic                 ovf_c;

`ifdef FP_ADD_RNE_EN
  logic inc, carry;
  always_comb begin
    inc             = norm[2] & (norm[1] | norm[0] | norm[3]);
    {carry, frac_p} = {1'b0, norm[VW-2:3]} + (MAN_W+1)'(inc);
    exp_p           = exp_n + signed'(EW'(carry));
  end
`else
  logic unused_grs;
  assign unused_grs = ^norm[2:0];
  always_comb begin
    frac_p = norm[VW-2:3];
    exp_p  = exp_n;
  end
`endif

  always_comb begin
    ovf_c = 1'b0;
    if (zero_r)                            res_c = '0;
    else if (exp_p >= EXP_INF) begin
      res_c = {sign_l, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
    end
    else if (exp_p[EW-1] || exp_p == '0)   res_c = {sign_l, {(FW-1){1'b0}}};
    else                                   res_c = {sign_l, exp_p[EXP_W-1:0], frac_p};
  end

  // Datapath registers, each loaded only in its own state
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        op_a <= a;
        op_b <= b;
      end
      ALIGN: begin
        sign_l  <= sl_c;
        eff_sub <= sl_c ^ ss_c;
        exp_l   <= el_c;
        vec_l   <= {ml_c, 3'b000};
        vec_s   <= vs_c;
      end
      ADD: sum <= eff_sub ? ({1'b0, vec_l} - {1'b0, vec_s})
                          : ({1'b0, vec_l} + {1'b0, vec_s});
      NORM: begin
        norm   <= norm_c;
        exp_n  <= exp_c;
        zero_r <= (sum == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else if (state == PACK) begin
      result_r <= res_c;
      ovf_r    <= ovf_c;
    end
  end

  assign result   = result_r;
  assign overflow = ovf_r;
endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Scoreboard bench for fp_add_seq_ctrl: expected {overflow,result} queued at issue, checked at handshake.
module tb_fp_add_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, overflow, busy;
  logic [31:0] result;

  int checks = 0, failures = 0;
  logic [32:0] sb[$];

  fp_add_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pop on every accepted result
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got=%h ovf=%b", result, overflow);
      end else begin
        e = sb.pop_front();
        if ({overflow, result} !== e) begin
          failures++;
          $display("FAIL result got=%h ovf=%b want=%h ovf=%b", result, overflow, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [32:0] ev);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
    end
    sb.push_back(ev);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || out_valid) && n < 50) begin @(posedge clk); #1; n++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL drain_timeout busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, overflow, result} !== {3'b100, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b ovf=%b res=%h want rdy=1 vld=0 busy=0 ovf=0 res=0",
               in_ready, out_valid, busy, overflow, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int n = 0;
    out_ready = 1'b1;
    sb.push_back({1'b0, 32'h40000000});
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL latency got=%0d edges want=4", n);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_one_cycle out_valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_arith();
    logic [31:0] ta[12] = '{32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
                            32'hBF800000, 32'hC0000000, 32'h80C00000, 32'h00000001,
                            32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h00000001};
    logic [31:0] tb2[12] = '{32'hBF800000, 32'hBF7FFFFF, 32'hBF800000, 32'h7F7FFFFF,
                             32'h3FC00000, 32'hC0000000, 32'h00800000, 32'h3F800000,
                             32'h33000000, 32'h32800000, 32'h3F800000, 32'h00000001};
    logic [32:0] te[12] = '{33'h03F000000, 33'h033800000, 33'h000000000, 33'h17F800000,
                            33'h03F000000, 33'h0C0800000, 33'h080000000, 33'h03F800000,
                            33'h03F800000, 33'h03F800000, 33'h17F800000, 33'h000000000};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(ta[i], tb2[i], te[i]);
      drain();
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    send(32'h40000000, 32'h3F800000, {1'b0, 32'h40400000});
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold cyc=%0d got vld=%b res=%h rdy=%b want vld=1 res=40400000 rdy=0",
                 i, out_valid, result, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL ignored_pulse busy_cycles=%0d want=0", n);
    end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    out_ready = 1'b1;
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;       // ALIGN
    in_valid = 1'b0;
    @(posedge clk); #1;       // ADD
    @(posedge clk); #1;       // NORM
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got rdy=%b busy=%b vld=%b want rdy=1 busy=0 vld=0", in_ready, busy, out_valid);
    end
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL dropped_op valid_cycles=%0d want=0", n);
    end
    send(32'h40000000, 32'h40000000, {1'b0, 32'h40800000});
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_backpressure();
    test_reset_midflight();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_add_seq_ctrl.md
Name: fp_add_seq_ctrl

Overview:
- Multi-cycle IEEE-754 single-precision adder with a valid/ready handshake on both sides.
- An FSM drives a shared align / add / normalize / pack datapath, one stage per cycle.
- The normalize stage instantiates count_leading_zeros, one instance only, on the 24-bit sum mantissa.
- Sits between the operand issue logic and the result writeback in the fp_adder top level.

Parameters:
- EXP_W, 8, exponent width (fixed for single precision; checked, not varied).
- MAN_W, 23, stored fraction width.
- DIFF_SAT, 26, exponent difference at or above which the smaller operand collapses to sticky only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- a  in  32  operand A
- b  in  32  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  sum
- overflow  out  1  result saturated to infinity (valid with out_valid)
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, busy=0.
- States: IDLE -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register a and b, then go to ALIGN.
  - in_ready=0 in every other state. No second operand is accepted until the result handshake completes.
- ALIGN:
  - Unpack operands. exp==0 is treated as zero (denormals flushed). Hidden bit = 1 otherwise.
  - Swap operands so that the larger magnitude is first.
  - Right-shift the smaller 24-bit mantissa by the exponent difference into a 27-bit {mant,G,R,S} vector. S is the OR of all bits shifted out.
  - If the difference is >= DIFF_SAT: smaller mantissa = 0, S = (smaller != 0).
- ADD:
  - Equal signs: add.
  - Otherwise: subtract smaller from larger.
  - 28-bit result with carry. Sign = sign of the larger operand.
- NORM:
  - carry=1: shift right 1 (sticky preserved), exp+1.
  - Otherwise: lz = count_leading_zeros(sum[26:3]) (24 when all zero). Left-shift the 27-bit vector by lz, exp -= lz.
  - All 27 bits zero: exact zero, result +0.
- PACK:
  - Truncate (round toward zero), unless the optional feature is enabled.
  - exp >= 255: result = {sign, 8'hFF, 23'h0}, overflow=1.
  - exp <= 0 after normalize: result = {sign, 31'h0}.
- DONE:
  - out_valid=1. result and overflow are held stable until out_ready.
  - On out_valid&out_ready: out_valid=0, go to IDLE.
- Latency: out_valid rises 4 clock edges after the accepting edge. Throughput is one operation per 6+ cycles.
- Operand encodings: exp==255 inputs are not special-cased; they are treated as huge normals and saturate to inf via the overflow path.
- rst asserted in any state: return to reset values next edge. The in-flight operation is dropped and no result is produced.
- out_ready high outside DONE: ignored.
- in_valid high outside IDLE: ignored. The operands are not sampled.

Optional Feature:
- Macro: FP_ADD_RNE_EN.
- Defined: PACK rounds to nearest-even using G, R, S.
  - Increment when G & (R|S|lsb).
  - Mantissa carry-out: renormalize (mantissa=0, exp+1), then apply the overflow check.
  - PACK remains one cycle.
- Undefined: truncation only. G, R and S are still computed but unused in PACK.

Test Plan:
- a=0x3F800000, b=0x3F800000, out_ready=1 -> result=0x40000000, overflow=0. out_valid exactly 4 edges after accept and high 1 cycle.
- a=0x3FC00000, b=0xBF800000 -> result=0x3F000000 (lz=1 normalize path).
- a=0x3F800000, b=0xBF7FFFFF -> result=0x33800000 (lz=24 full cancellation into guard bit).
- a=0x3F800000, b=0xBF800000 -> result=0x00000000. Then a=0x7F7FFFFF, b=0x7F7FFFFF -> result=0x7F800000, overflow=1.
- Backpressure check, steps:
  - Hold out_ready=0 for 3 cycles in DONE: result/out_valid stay stable and in_ready=0.
  - Pulse in_valid with new operands during DONE: the pulse is ignored.
  - Raise out_ready: FSM returns to IDLE, in_ready=1.
- Assert rst for 1 cycle while in NORM -> next cycle state=IDLE, in_ready=1, out_valid never rises. A following a=0x40000000, b=0x40000000 produces 0x40800000.
